// File: rtl/shift_sar_pkg.sv
// Shared encodings and constants for the shift-register command sequencer
// and its shadow model.
package shift_sar_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int MAX_LEN       = 16;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHL  = 2'b01,
    OP_SHR  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    MOD_SHL  = 2'b00,
    MOD_SHR  = 2'b01,
    MOD_LOAD = 2'b10,
    MOD_CLR  = 2'b11
  } mod_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  // A zero-length shift still occupies one hold step so every command pulses done.
  function automatic logic [4:0] stepCount(input logic [1:0] op, input logic [4:0] len);
    logic [4:0] cnt;
    if (op == OP_LOAD || op == OP_CLR) begin
      cnt = 5'd1;
    end else if (len == 5'd0) begin
      cnt = 5'd1;
    end else if (len > 5'(MAX_LEN)) begin
      cnt = 5'(MAX_LEN);
    end else begin
      cnt = len;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/shift_sar_seq_shadow.sv
// Next-value function of the downstream universal shift register, used to keep
// the sequencer's shadow copy in lock-step with the real register.
module sar_shadow_model
  import shift_sar_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [1:0]       mod_i,
  input  logic             rightin_i,
  input  logic             leftin_i,
  input  logic [WIDTH-1:0] pin_i,
  input  logic [WIDTH-1:0] cur_i,
  output logic [WIDTH-1:0] next_o
);

  always_comb begin
    next_o = cur_i;
    case (mod_i)
      MOD_SHL:  next_o = {cur_i[WIDTH-2:0], rightin_i};
      MOD_SHR:  next_o = {leftin_i, cur_i[WIDTH-1:1]};
      MOD_LOAD: next_o = pin_i;
      MOD_CLR:  next_o = '0;
      default:  next_o = cur_i;
    endcase
  end

endmodule

// File: rtl/shift_sar_seq.sv
// Command sequencer that expands LOAD/SHL/SHR/CLR commands into per-cycle
// controls for a hold-less universal shift register, reloading a shadow copy when idle.
module shift_sar_seq
  import shift_sar_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [4:0]       cmd_len_i,
  input  logic [WIDTH-1:0] cmd_data_i,
  output logic [1:0]       mod_o,
  output logic             rightin_o,
  output logic             leftin_o,
  output logic [WIDTH-1:0] pin_o,
  output logic             done_o,
  output logic [WIDTH-1:0] shadow_o
);

  state_e           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic             noop_q, noop_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] shadow_q, shadowNext;

  // Outputs decode only registered state; cmd_* inputs steer next-state only.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    noop_d      = noop_q;
    data_d      = data_q;
    mod_o       = MOD_LOAD;
    pin_o       = shadow_q;
    rightin_o   = 1'b0;
    leftin_o    = 1'b0;
    done_o      = 1'b0;
    cmd_ready_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready_o = !rst_i;
        if (cmd_valid_i) begin
          op_d    = op_e'(cmd_op_i);
          data_d  = cmd_data_i;
          cnt_d   = stepCount(cmd_op_i, cmd_len_i);
          noop_d  = (cmd_op_i == OP_SHL || cmd_op_i == OP_SHR) && (cmd_len_i == 5'd0);
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        // Shift data is consumed LSB-first, so the current serial bit is always data_q[0].
        case (op_q)
          OP_LOAD: pin_o = data_q;
          OP_CLR:  mod_o = MOD_CLR;
          OP_SHL: begin
            if (!noop_q) begin
              mod_o     = MOD_SHL;
              rightin_o = data_q[0];
            end
            data_d = data_q >> 1;
          end
          OP_SHR: begin
            if (!noop_q) begin
              mod_o    = MOD_SHR;
              leftin_o = data_q[0];
            end
            data_d = data_q >> 1;
          end
          default: mod_o = MOD_LOAD;
        endcase

        cnt_d = cnt_q - 5'd1;
        if (cnt_q <= 5'd1) begin
          done_o  = 1'b1;
          cnt_d   = 5'd0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      op_q    <= OP_LOAD;
      noop_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      noop_q  <= noop_d;
      data_q  <= data_d;
    end
  end

  sar_shadow_model #(
    .WIDTH(WIDTH)
  ) u_shadow (
    .mod_i    (mod_o),
    .rightin_i(rightin_o),
    .leftin_i (leftin_o),
    .pin_i    (pin_o),
    .cur_i    (shadow_q),
    .next_o   (shadowNext)
  );

  // The downstream register clears on the same reset, so the shadow does too.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadowNext;
    end
  end

  assign shadow_o = shadow_q;

endmodule

// File: tb/tb_shift_sar_seq.sv
// Self-checking bench for shift_sar_seq: a queue-based command model predicts
// every cycle's controls and register value; directed literals pin the model.
module tb_shift_sar_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmdValid = 1'b0;
  logic [1:0]  cmdOp = 2'd0;
  logic [4:0]  cmdLen = 5'd0;
  logic [15:0] cmdData = 16'h0;
  logic        cmdReady;
  logic [1:0]  mod;
  logic        rightin;
  logic        leftin;
  logic [15:0] pin;
  logic        done;
  logic [15:0] shadow;

  int nVectors = 0;
  int nMiscompares = 0;
  int cycleCnt = 0;

  always #5 clk = ~clk;

  shift_sar_seq #(.WIDTH(16)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cmd_valid_i(cmdValid),
    .cmd_ready_o(cmdReady),
    .cmd_op_i   (cmdOp),
    .cmd_len_i  (cmdLen),
    .cmd_data_i (cmdData),
    .mod_o      (mod),
    .rightin_o  (rightin),
    .leftin_o   (leftin),
    .pin_o      (pin),
    .done_o     (done),
    .shadow_o   (shadow)
  );

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", name, actual, expected, $time);
    end
  endtask

  // Model: each accepted command becomes a list of per-cycle control steps.
  typedef struct {
    logic [1:0]  mod;
    logic        rin;
    logic        lin;
    logic        isLoad;
    logic [15:0] data;
  } step_t;

  step_t       stepQ[$];
  logic [15:0] mdlReg = 16'h0;
  bit          mdlValid = 1'b0;

  function automatic step_t holdStep();
    step_t s;
    s = '{mod: 2'b10, rin: 1'b0, lin: 1'b0, isLoad: 1'b0, data: 16'h0};
    return s;
  endfunction

  function automatic void expandCommand(input logic [1:0] op, input logic [4:0] len, input logic [15:0] data);
    step_t s;
    int n;
    s = holdStep();
    if (op == 2'b00) begin
      s.isLoad = 1'b1;
      s.data   = data;
      stepQ.push_back(s);
    end else if (op == 2'b11) begin
      s.mod = 2'b11;
      stepQ.push_back(s);
    end else begin
      n = (int'(len) > 16) ? 16 : int'(len);
      if (n == 0) begin
        stepQ.push_back(s);
      end else begin
        for (int k = 0; k < n; k++) begin
          s = holdStep();
          if (op == 2'b01) begin
            s.mod = 2'b00;
            s.rin = data[k];
          end else begin
            s.mod = 2'b01;
            s.lin = data[k];
          end
          stepQ.push_back(s);
        end
      end
    end
  endfunction

  function automatic logic [15:0] registerAfter(input step_t s, input logic [15:0] r);
    int v;
    v = int'(r);
    case (s.mod)
      2'b00:   v = (v * 2 + int'(s.rin)) % 65536;
      2'b01:   v = v / 2 + int'(s.lin) * 32768;
      2'b10:   v = s.isLoad ? int'(s.data) : v;
      default: v = 0;
    endcase
    return 16'(v);
  endfunction

  always @(posedge clk) begin : modelProc
    step_t s;
    if (rst) begin
      stepQ.delete();
      mdlReg   = 16'h0;
      mdlValid = 1'b1;
    end else if (mdlValid) begin
      if (stepQ.size() != 0) begin
        s      = stepQ.pop_front();
        mdlReg = registerAfter(s, mdlReg);
      end else if (cmdValid) begin
        expandCommand(cmdOp, cmdLen, cmdData);
      end
    end
  end

  always @(negedge clk) begin : compareProc
    logic [1:0]  eMod;
    logic        eRin, eLin, eDone, eReady;
    logic [15:0] ePin;
    if (mdlValid) begin
      if (stepQ.size() != 0) begin
        eMod   = stepQ[0].mod;
        eRin   = stepQ[0].rin;
        eLin   = stepQ[0].lin;
        ePin   = stepQ[0].isLoad ? stepQ[0].data : mdlReg;
        eDone  = (stepQ.size() == 1);
        eReady = 1'b0;
      end else begin
        eMod   = 2'b10;
        eRin   = 1'b0;
        eLin   = 1'b0;
        ePin   = mdlReg;
        eDone  = 1'b0;
        eReady = !rst;
      end
      checkOutput("model.mod", 16'(mod), 16'(eMod));
      checkOutput("model.rightin", 16'(rightin), 16'(eRin));
      checkOutput("model.leftin", 16'(leftin), 16'(eLin));
      checkOutput("model.pin", pin, ePin);
      checkOutput("model.done", 16'(done), 16'(eDone));
      checkOutput("model.cmd_ready", 16'(cmdReady), 16'(eReady));
      checkOutput("model.shadow", shadow, mdlReg);
    end
  end

  // Present a command and hold it until accepted; returns just after the accept edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [4:0] len, input logic [15:0] data);
    bit accepted;
    accepted = 1'b0;
    cmdOp    = op;
    cmdLen   = len;
    cmdData  = data;
    cmdValid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (cmdReady) begin
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!accepted) begin
      checkOutput("acceptTimeout", 16'd0, 16'd1);
      cmdValid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      cmdValid = 1'b0;
      cmdOp    = 2'($urandom);
      cmdLen   = 5'($urandom);
      cmdData  = 16'($urandom);
    end
  endtask

  initial begin : mainProc
    logic [3:0] shlBits;
    int tA, tB;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset.mod", 16'(mod), 16'h2);
    checkOutput("reset.pin", pin, 16'h0000);
    checkOutput("reset.shadow", shadow, 16'h0000);
    checkOutput("reset.done", 16'(done), 16'h0);
    checkOutput("reset.cmd_ready", 16'(cmdReady), 16'h1);

    #1 applyStimulus(2'b00, 5'd0, 16'hA5C3);
    @(negedge clk);
    checkOutput("load.mod", 16'(mod), 16'h2);
    checkOutput("load.pin", pin, 16'hA5C3);
    checkOutput("load.done", 16'(done), 16'h1);
    @(negedge clk);
    checkOutput("load.shadow", shadow, 16'hA5C3);
    checkOutput("load.ready", 16'(cmdReady), 16'h1);
    checkOutput("load.pinHold", pin, 16'hA5C3);

    #1 applyStimulus(2'b00, 5'd0, 16'h1234);
    applyStimulus(2'b01, 5'd4, 16'h000B);
    shlBits = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("shl.mod", 16'(mod), 16'h0);
      checkOutput("shl.rightin", 16'(rightin), 16'(shlBits[k]));
      checkOutput("shl.done", 16'(done), (k == 3) ? 16'h1 : 16'h0);
    end
    @(negedge clk);
    checkOutput("shl.shadow", shadow, 16'h234D);

    #1 applyStimulus(2'b11, 5'd9, 16'h7777);
    @(negedge clk);
    checkOutput("clr0.mod", 16'(mod), 16'h3);
    @(negedge clk);
    checkOutput("clr0.shadow", shadow, 16'h0000);

    #1 applyStimulus(2'b10, 5'd20, 16'hFFFF);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checkOutput("shr.mod", 16'(mod), 16'h1);
      checkOutput("shr.leftin", 16'(leftin), 16'h1);
      checkOutput("shr.done", 16'(done), (k == 15) ? 16'h1 : 16'h0);
    end
    @(negedge clk);
    checkOutput("shr.idleMod", 16'(mod), 16'h2);
    checkOutput("shr.shadow", shadow, 16'hFFFF);

    #1 applyStimulus(2'b01, 5'd0, 16'h5A5A);
    @(negedge clk);
    checkOutput("noop.mod", 16'(mod), 16'h2);
    checkOutput("noop.done", 16'(done), 16'h1);
    checkOutput("noop.pin", pin, 16'hFFFF);
    @(negedge clk);
    checkOutput("noop.shadow", shadow, 16'hFFFF);

    #1 applyStimulus(2'b11, 5'd0, 16'h0000);
    @(negedge clk);
    checkOutput("clr.mod", 16'(mod), 16'h3);
    checkOutput("clr.done", 16'(done), 16'h1);
    @(negedge clk);
    checkOutput("clr.shadow", shadow, 16'h0000);

    #1 applyStimulus(2'b00, 5'd0, 16'h8001);
    applyStimulus(2'b01, 5'd8, 16'h00FF);
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("midReset.mod", 16'(mod), 16'h2);
    checkOutput("midReset.pin", pin, 16'h0000);
    checkOutput("midReset.done", 16'(done), 16'h0);
    checkOutput("midReset.shadow", shadow, 16'h0000);

    #1 applyStimulus(2'b10, 5'd4, 16'h0003);
    tA = cycleCnt;
    applyStimulus(2'b01, 5'd3, 16'h0005);
    tB = cycleCnt;
    checkOutput("heldValid.latency", 16'(tB - tA), 16'd5);

    for (int i = 0; i < 200; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), 5'($urandom_range(0, 20)), 16'($urandom));
      if ($urandom_range(0, 15) == 0) begin
        repeat ($urandom_range(0, 5)) @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
      end else begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end

    repeat (20) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
